// File: rtl/io_mem_sram_ctrl.sv
// Buffered external SRAM sequencer.
// Queues skin requests and replays them as SETUP/ACCESS/HOLD bus cycles.
module io_mem_sram_ctrl #(
    parameter int DW     = 32,
    parameter int DEPTH  = 2,
    parameter int WAIT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_r_en,
    input  logic              i_req_w_en,
    input  logic [DW-1:0]     i_req_addr,
    input  logic [DW-1:0]     i_req_w_data,
    output logic              o_req_ready,
    output logic [DW-1:0]     o_rsp_r_data,
    output logic              o_rsp_valid,
    output logic              o_err,
    output logic              o_busy,
    input  logic [WAIT_W-1:0] i_wait_states,
    output logic              o_sram_cs,
    output logic              o_sram_oe,
    output logic              o_sram_we,
    output logic [DW-1:0]     o_sram_addr,
    output logic [DW-1:0]     o_sram_wdata,
    input  logic [DW-1:0]     i_sram_rdata
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD
    } state_t;

    state_t            state;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              q_wr   [DEPTH];
    logic [DW-1:0]     q_addr [DEPTH];
    logic [DW-1:0]     q_data [DEPTH];
    logic [WAIT_W-1:0] cnt;
    logic              is_wr;
    logic              req;
    logic              push;
    logic              pop;

    assign req         = i_req_r_en | i_req_w_en;
    assign o_req_ready = (count < FULL);
    assign push        = o_req_ready & req;
    assign pop         = ((state == IDLE) || (state == HOLD)) && (count != '0);
    assign o_busy      = (state != IDLE) || (count != '0);

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            q_wr[wr_ptr]   <= i_req_w_en;
            q_addr[wr_ptr] <= i_req_addr;
            q_data[wr_ptr] <= i_req_w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            cnt          <= '0;
            is_wr        <= 1'b0;
            o_err        <= 1'b0;
            o_rsp_valid  <= 1'b0;
            o_rsp_r_data <= '0;
            o_sram_cs    <= 1'b0;
            o_sram_oe    <= 1'b0;
            o_sram_we    <= 1'b0;
            o_sram_addr  <= '0;
            o_sram_wdata <= '0;
        end else begin
            o_err       <= push & i_req_r_en & i_req_w_en;
            o_rsp_valid <= 1'b0;

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            case (state)
                IDLE: begin
                    if (pop) begin
                        state        <= SETUP;
                        o_sram_cs    <= 1'b1;
                        o_sram_addr  <= q_addr[rd_ptr];
                        o_sram_wdata <= q_data[rd_ptr];
                        is_wr        <= q_wr[rd_ptr];
                        cnt          <= i_wait_states;
                    end
                end
                SETUP: begin
                    state     <= ACCESS;
                    o_sram_we <= is_wr;
                    o_sram_oe <= ~is_wr;
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        state     <= HOLD;
                        o_sram_we <= 1'b0;
                        o_sram_oe <= 1'b0;
                        if (!is_wr) begin
                            o_rsp_r_data <= i_sram_rdata;
                            o_rsp_valid  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    // Chain straight into the next access so cs stays high.
                    if (pop) begin
                        state        <= SETUP;
                        o_sram_addr  <= q_addr[rd_ptr];
                        o_sram_wdata <= q_data[rd_ptr];
                        is_wr        <= q_wr[rd_ptr];
                        cnt          <= i_wait_states;
                    end else begin
                        state     <= IDLE;
                        o_sram_cs <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_mem_sram_ctrl.sv
// Bench for io_mem_sram_ctrl: directed literal checks plus a random run
// compared every cycle against a timeline model of the request queue.
module tb_io_mem_sram_ctrl;

    localparam int DW     = 32;
    localparam int DEPTH  = 2;
    localparam int WAIT_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_req_r_en;
    logic              i_req_w_en;
    logic [DW-1:0]     i_req_addr;
    logic [DW-1:0]     i_req_w_data;
    logic              o_req_ready;
    logic [DW-1:0]     o_rsp_r_data;
    logic              o_rsp_valid;
    logic              o_err;
    logic              o_busy;
    logic [WAIT_W-1:0] i_wait_states;
    logic              o_sram_cs;
    logic              o_sram_oe;
    logic              o_sram_we;
    logic [DW-1:0]     o_sram_addr;
    logic [DW-1:0]     o_sram_wdata;
    logic [DW-1:0]     i_sram_rdata;

    io_mem_sram_ctrl #(.DW(DW), .DEPTH(DEPTH), .WAIT_W(WAIT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req_r_en   (i_req_r_en),
        .i_req_w_en   (i_req_w_en),
        .i_req_addr   (i_req_addr),
        .i_req_w_data (i_req_w_data),
        .o_req_ready  (o_req_ready),
        .o_rsp_r_data (o_rsp_r_data),
        .o_rsp_valid  (o_rsp_valid),
        .o_err        (o_err),
        .o_busy       (o_busy),
        .i_wait_states(i_wait_states),
        .o_sram_cs    (o_sram_cs),
        .o_sram_oe    (o_sram_oe),
        .o_sram_we    (o_sram_we),
        .o_sram_addr  (o_sram_addr),
        .o_sram_wdata (o_sram_wdata),
        .i_sram_rdata (i_sram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
    } req_t;

    req_t        q[$];
    req_t        cur;
    bit          act;
    int          s_edge;
    int          m_n;
    int          cyc;
    int          n_tests;
    int          n_fail;
    int          rsp_seen;
    bit          rd_fixed;

    bit          e_cs, e_oe, e_we, e_rv, e_err, e_rdy, e_busy;
    logic [31:0] e_addr, e_wd, e_rd;

    function automatic void chk(string nm, logic [31:0] act_v,
                                logic [31:0] exp_v);
        n_tests++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act_v, exp_v, cyc);
        end
    endfunction

    // Access started at edge s occupies: p=0 SETUP, 1..N+1 ACCESS, N+2 HOLD.
    task automatic model_step();
        bit   free;
        bit   can_push;
        bit   pushed;
        req_t nr;
        int   p;
        cyc++;
        if (rst) begin
            q.delete();
            act    = 0;
            e_cs   = 0; e_oe = 0; e_we = 0; e_rv = 0; e_err = 0;
            e_rdy  = 1; e_busy = 0;
            e_addr = '0; e_wd = '0; e_rd = '0;
            return;
        end
        can_push = (q.size() < DEPTH);
        free     = !act || ((cyc - 1 - s_edge) == m_n + 2);
        if (free) begin
            act = 0;
            if (q.size() != 0) begin
                cur    = q.pop_front();
                act    = 1;
                s_edge = cyc;
                m_n    = int'(i_wait_states);
                e_addr = cur.a;
                e_wd   = cur.d;
            end
        end
        pushed = can_push && (i_req_r_en || i_req_w_en);
        if (pushed) begin
            nr.w = i_req_w_en;
            nr.a = i_req_addr;
            nr.d = i_req_w_data;
            q.push_back(nr);
        end
        e_rv = 0;
        if (act) begin
            p    = cyc - s_edge;
            e_cs = 1;
            e_we = (p >= 1 && p <= m_n + 1) && cur.w;
            e_oe = (p >= 1 && p <= m_n + 1) && !cur.w;
            if (p == m_n + 2 && !cur.w) begin
                e_rv = 1;
                e_rd = i_sram_rdata;
            end
        end else begin
            e_cs = 0; e_we = 0; e_oe = 0;
        end
        e_err  = pushed && i_req_r_en && i_req_w_en;
        e_rdy  = (q.size() < DEPTH);
        e_busy = act || (q.size() != 0);
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("cs",    32'(o_sram_cs),   32'(e_cs));
            chk("oe",    32'(o_sram_oe),   32'(e_oe));
            chk("we",    32'(o_sram_we),   32'(e_we));
            chk("rv",    32'(o_rsp_valid), 32'(e_rv));
            chk("err",   32'(o_err),       32'(e_err));
            chk("ready", 32'(o_req_ready), 32'(e_rdy));
            chk("busy",  32'(o_busy),      32'(e_busy));
            chk("addr",  o_sram_addr,      e_addr);
            chk("wdata", o_sram_wdata,     e_wd);
            chk("rdata", o_rsp_r_data,     e_rd);
            if (o_rsp_valid) rsp_seen++;
        end
    end

    task automatic cycle();
        if (!rd_fixed) i_sram_rdata = $urandom;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cycle();
    endtask

    task automatic send(input bit r, input bit w,
                        input logic [31:0] a, input logic [31:0] d);
        i_req_r_en   = r;
        i_req_w_en   = w;
        i_req_addr   = a;
        i_req_w_data = d;
        cycle();
        i_req_r_en   = 0;
        i_req_w_en   = 0;
    endtask

    initial begin
        int base;
        int kind;
        n_tests = 0; n_fail = 0; cyc = 0; rsp_seen = 0;
        act = 0; rd_fixed = 0;
        rst = 1;
        i_req_r_en = 0; i_req_w_en = 0;
        i_req_addr = '0; i_req_w_data = '0;
        i_wait_states = '0; i_sram_rdata = '0;

        idle(3);
        rst = 0;
        chk("t1_cs",    32'(o_sram_cs),   0);
        chk("t1_ready", 32'(o_req_ready), 1);
        chk("t1_busy",  32'(o_busy),      0);
        idle(10);

        i_wait_states = 0;
        send(0, 1, 32'h10, 32'hDEADBEEF);
        chk("t2_cs_T", 32'(o_sram_cs), 0);
        cycle();
        chk("t2_cs_T1", 32'(o_sram_cs), 1);
        chk("t2_we_T1", 32'(o_sram_we), 0);
        cycle();
        chk("t2_we_T2",   32'(o_sram_we), 1);
        chk("t2_addr_T2", o_sram_addr,    32'h10);
        chk("t2_wd_T2",   o_sram_wdata,   32'hDEADBEEF);
        cycle();
        chk("t2_cs_T3", 32'(o_sram_cs),   1);
        chk("t2_we_T3", 32'(o_sram_we),   0);
        chk("t2_rv_T3", 32'(o_rsp_valid), 0);
        cycle();
        chk("t2_cs_T4", 32'(o_sram_cs), 0);
        idle(2);

        rd_fixed = 1;
        i_sram_rdata = 32'h12345678;
        i_wait_states = 2;
        send(1, 0, 32'h20, 32'h0);
        cycle();
        chk("t3_oe_T1", 32'(o_sram_oe), 0);
        for (int i = 2; i <= 4; i++) begin
            cycle();
            chk("t3_oe_acc", 32'(o_sram_oe), 1);
        end
        cycle();
        chk("t3_rv_T5", 32'(o_rsp_valid), 1);
        chk("t3_rd_T5", o_rsp_r_data,     32'h12345678);
        chk("t3_oe_T5", 32'(o_sram_oe),   0);
        cycle();
        chk("t3_rv_T6", 32'(o_rsp_valid), 0);
        rd_fixed = 0;
        idle(2);

        i_wait_states = 1;
        base = rsp_seen;
        send(1, 0, 32'h40, 0);
        send(1, 0, 32'h44, 0);
        send(1, 0, 32'h48, 0);
        idle(16);
        chk("t4_rsp_count", 32'(rsp_seen - base), 3);

        i_wait_states = 0;
        send(1, 1, 32'h30, 32'hA5A5A5A5);
        chk("t5_err_T", 32'(o_err), 1);
        cycle();
        chk("t5_err_T1", 32'(o_err), 0);
        cycle();
        chk("t5_we_T2", 32'(o_sram_we), 1);
        chk("t5_wd_T2", o_sram_wdata,   32'hA5A5A5A5);
        cycle();
        chk("t5_rv_T3", 32'(o_rsp_valid), 0);
        idle(2);

        i_wait_states = 5;
        send(1, 0, 32'h50, 0);
        idle(4);
        chk("t6_oe_acc3", 32'(o_sram_oe), 1);
        rst = 1;
        cycle();
        rst = 0;
        chk("t6_cs",    32'(o_sram_cs),   0);
        chk("t6_oe",    32'(o_sram_oe),   0);
        chk("t6_ready", 32'(o_req_ready), 1);
        chk("t6_busy",  32'(o_busy),      0);
        base = rsp_seen;
        idle(10);
        chk("t6_no_rsp", 32'(rsp_seen - base), 0);

        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 79) == 0);
            i_wait_states = ($urandom_range(0, 9) == 0) ?
                            WAIT_W'($urandom_range(0, 15)) :
                            WAIT_W'($urandom_range(0, 3));
            kind = $urandom_range(0, 9);
            i_req_addr   = $urandom;
            i_req_w_data = $urandom;
            i_req_r_en   = (kind >= 4 && kind <= 6) || kind == 9;
            i_req_w_en   = (kind >= 7);
            if (kind == 9 && q.size() >= DEPTH) i_req_r_en = 0;
            cycle();
        end
        rst = 0;
        i_req_r_en = 0;
        i_req_w_en = 0;
        idle(40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
